writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 144 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Merges two register-file write sources into a single write port:
//   * ALU results, which have no backpressure and always win the port.
//   * Load results, which are buffered in a small FIFO and commit only in
//     cycles where no ALU result is present.
// A pending-load scoreboard marks registers with a load in flight. A bit is
// set when the load is issued and cleared when that load commits.
//
// Ports
//   clock, reset                   core clock; asynchronous active-high reset
//   aluValid/aluAddress/aluData    ALU result, one cycle, no stall
//   loadValid/loadReady            load result handshake (transfer on both high)
//   loadAddress/loadData           load result destination and value
//   issueValid/issueAddress        load issue; marks destination pending
//   rdAddress/rd/rdWriteEnable     registered register-file write port
//   pendingMask                    registered outstanding-load mask (bit 0 = 0)
// ---------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int LOAD_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        aluValid,
   input  logic [4:0]  aluAddress,
   input  logic [31:0] aluData,
   input  logic        loadValid,
   output logic        loadReady,
   input  logic [4:0]  loadAddress,
   input  logic [31:0] loadData,
   input  logic        issueValid,
   input  logic [4:0]  issueAddress,
   output logic [4:0]  rdAddress,
   output logic [31:0] rd,
   output logic        rdWriteEnable,
   output logic [31:0] pendingMask
);

   localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Load queue storage and pointers. Pointer width matches the power-of-two
   // depth, so the increments wrap naturally.
   logic [4:0]       q_addr_q [LOAD_DEPTH];
   logic [31:0]      q_data_q [LOAD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_we_q, rd_we_d;
   logic [31:0] pend_q, pend_d;

   logic        load_ready;
   logic        push;
   logic        pop;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   always_comb begin
      // Ready depends only on the registered count. A pop this cycle does not
      // free a slot until the next cycle.
      load_ready = (count_q < CNT_W'(LOAD_DEPTH));
      push       = loadValid && load_ready;
      head_addr  = q_addr_q[rd_ptr_q];
      head_data  = q_data_q[rd_ptr_q];
      // The queue head uses the port only when the ALU leaves it idle. An
      // entry pushed this cycle is not yet counted, so it cannot bypass.
      pop        = !aluValid && (count_q != '0);

      rd_we_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (aluValid) begin
         if (aluAddress != 5'd0) begin
            rd_we_d   = 1'b1;
            rd_addr_d = aluAddress;
            rd_data_d = aluData;
         end
      end else if (pop) begin
         if (head_addr != 5'd0) begin
            rd_we_d   = 1'b1;
            rd_addr_d = head_addr;
            rd_data_d = head_data;
         end
      end

      // Clear first, then set, so a same-edge issue to the same register
      // keeps the bit high.
      pend_d = pend_q;
      if (pop) begin
         pend_d[head_addr] = 1'b0;
      end
      if (issueValid) begin
         pend_d[issueAddress] = 1'b1;
      end
      pend_d[0] = 1'b0;

      wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
         rd_we_q   <= 1'b0;
         pend_q    <= '0;
         for (int i = 0; i < LOAD_DEPTH; i++) begin
            q_addr_q[i] <= '0;
            q_data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         rd_we_q   <= rd_we_d;
         pend_q    <= pend_d;
         if (push) begin
            q_addr_q[wr_ptr_q] <= loadAddress;
            q_data_q[wr_ptr_q] <= loadData;
         end
      end
   end

   assign loadReady     = load_ready;
   assign rdAddress     = rd_addr_q;
   assign rd            = rd_data_q;
   assign rdWriteEnable = rd_we_q;
   assign pendingMask   = pend_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Self-checking bench for writeback_arbiter. It runs the following parts:
//   * a table of directed vectors with hand-derived expected outputs,
//   * directed sequences for queue full/stall and asynchronous reset,
//   * randomized stimulus compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_v;
   logic [4:0]  alu_a;
   logic [31:0] alu_d;
   logic        ld_v;
   logic        ld_rdy;
   logic [4:0]  ld_a;
   logic [31:0] ld_d;
   logic        is_v;
   logic [4:0]  is_a;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_we;
   logic [31:0] pend;

   always #5 clk = ~clk;

   writeback_arbiter #(.LOAD_DEPTH(DEPTH)) dut (
      .clock         (clk),
      .reset         (reset),
      .aluValid      (alu_v),
      .aluAddress    (alu_a),
      .aluData       (alu_d),
      .loadValid     (ld_v),
      .loadReady     (ld_rdy),
      .loadAddress   (ld_a),
      .loadData      (ld_d),
      .issueValid    (is_v),
      .issueAddress  (is_a),
      .rdAddress     (rd_addr),
      .rd            (rd_data),
      .rdWriteEnable (rd_we),
      .pendingMask   (pend)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pend;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_rd;
   logic        m_ready;

   task automatic model_reset();
      mq.delete();
      m_pend  = '0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_rd    = '0;
      m_ready = 1'b1;
   endtask

   // One clock of the model. It uses the current inputs and the state from
   // before the edge.
   task automatic model_cycle();
      int   sz;
      bit   ready;
      ent_t h;
      sz    = mq.size();
      ready = (sz < DEPTH);
      m_we  = 1'b0;
      if (alu_v) begin
         if (alu_a != 0) begin
            m_we = 1'b1; m_addr = alu_a; m_rd = alu_d;
         end
      end else if (sz > 0) begin
         h = mq.pop_front();
         if (h.a != 0) begin
            m_we = 1'b1; m_addr = h.a; m_rd = h.d;
         end
         m_pend[h.a] = 1'b0;
      end
      if (is_v && is_a != 0) m_pend[is_a] = 1'b1;
      m_pend[0] = 1'b0;
      if (ld_v && ready) mq.push_back({ld_a, ld_d});
      m_ready = (mq.size() < DEPTH);
   endtask

   task automatic check_model(input string name);
      n_checks++;
      if (rd_we !== m_we || (m_we && (rd_addr !== m_addr || rd_data !== m_rd)) ||
          pend !== m_pend || ld_rdy !== m_ready) begin
         n_fail++;
         $display("FAIL %s: got we=%0b addr=%0d rd=%h pend=%h rdy=%0b, want we=%0b addr=%0d rd=%h pend=%h rdy=%0b",
                  name, rd_we, rd_addr, rd_data, pend, ld_rdy, m_we, m_addr, m_rd, m_pend, m_ready);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic idle_inputs();
      alu_v = 0; alu_a = 0; alu_d = 0;
      ld_v  = 0; ld_a  = 0; ld_d  = 0;
      is_v  = 0; is_a  = 0;
   endtask

   // Advance one clock and compare with the model 1 time unit after the edge.
   task automatic step(input string name);
      model_cycle();
      @(posedge clk);
      #1;
      check_model(name);
      $display("cyc %s: alu=%0b/%0d ld=%0b/%0d iss=%0b/%0d -> we=%0b addr=%0d rd=%h pend=%h rdy=%0b",
               name, alu_v, alu_a, ld_v, ld_a, is_v, is_a, rd_we, rd_addr, rd_data, pend, ld_rdy);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        alu_v;
      logic [4:0]  alu_a;
      logic [31:0] alu_d;
      logic        ld_v;
      logic [4:0]  ld_a;
      logic [31:0] ld_d;
      logic        is_v;
      logic [4:0]  is_a;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_rd;
      logic [31:0] e_pend;
      logic        e_rdy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   initial begin
      // Each vector gives the inputs applied for one cycle and the outputs
      // expected right after that edge.
      vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,   1'b1};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b1};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80,  1'b1};
      vecs[3]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd3, 32'h11,       32'h80,  1'b1};
      vecs[4]  = '{1'b1, 5'd4, 32'h22,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd4, 32'h22,       32'h80,  1'b1};
      vecs[5]  = '{1'b1, 5'd6, 32'h33,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd6, 32'h33,       32'h80,  1'b1};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, 32'h0,   1'b1};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 32'h12345678, 32'h0,   1'b1};
      vecs[8]  = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66,       1'b0, 5'd0, 1'b0, 5'd7, 32'h12345678, 32'h0,   1'b1};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 32'h12345678, 32'h0,   1'b1};
      vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAB,       1'b1, 5'd9, 1'b0, 5'd7, 32'h12345678, 32'h200, 1'b1};
      vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd9, 32'hAB,       32'h200, 1'b1};
      vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 32'hAB,       32'h200, 1'b1};
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      model_reset();
      #1;
      check_val("reset_we",    {31'd0, rd_we}, 32'd0);
      check_val("reset_rd",    rd_data,        32'd0);
      check_val("reset_addr",  {27'd0, rd_addr}, 32'd0);
      check_val("reset_pend",  pend,           32'd0);
      check_val("reset_ready", {31'd0, ld_rdy}, 32'd1);
      do_reset();

      // Directed table.
      for (int i = 0; i < NV; i++) begin
         alu_v = vecs[i].alu_v; alu_a = vecs[i].alu_a; alu_d = vecs[i].alu_d;
         ld_v  = vecs[i].ld_v;  ld_a  = vecs[i].ld_a;  ld_d  = vecs[i].ld_d;
         is_v  = vecs[i].is_v;  is_a  = vecs[i].is_a;
         step($sformatf("vec%0d", i));
         n_checks++;
         if (rd_we !== vecs[i].e_we || rd_addr !== vecs[i].e_addr || rd_data !== vecs[i].e_rd ||
             pend !== vecs[i].e_pend || ld_rdy !== vecs[i].e_rdy) begin
            n_fail++;
            $display("FAIL table vec%0d: got we=%0b addr=%0d rd=%h pend=%h rdy=%0b, want we=%0b addr=%0d rd=%h pend=%h rdy=%0b",
                     i, rd_we, rd_addr, rd_data, pend, ld_rdy,
                     vecs[i].e_we, vecs[i].e_addr, vecs[i].e_rd, vecs[i].e_pend, vecs[i].e_rdy);
         end
      end
      idle_inputs();

      // Queue full and stall: the ALU holds the port while two loads fill the queue.
      do_reset();
      alu_v = 1; alu_a = 5'd1; alu_d = 32'h1;
      ld_v = 1; ld_a = 5'd10; ld_d = 32'hA0;
      step("full_push_a");
      ld_a = 5'd11; ld_d = 32'hB0;
      step("full_push_b");
      check_val("full_ready_low", {31'd0, ld_rdy}, 32'd0);
      ld_a = 5'd12; ld_d = 32'hC0;
      step("full_stall_c");
      check_val("full_still_low", {31'd0, ld_rdy}, 32'd0);
      alu_v = 0;
      step("drain_a");
      check_val("drain_a_addr", {27'd0, rd_addr}, 32'd10);
      check_val("drain_a_ready", {31'd0, ld_rdy}, 32'd1);
      step("drain_b_push_c");
      check_val("drain_b_addr", {27'd0, rd_addr}, 32'd11);
      ld_v = 0;
      step("drain_c");
      check_val("drain_c_addr", {27'd0, rd_addr}, 32'd12);
      check_val("drain_c_we", {31'd0, rd_we}, 32'd1);
      step("drain_idle");

      // Asynchronous reset with two queued loads and x7 and x9 pending.
      do_reset();
      alu_v = 1; alu_a = 5'd2; alu_d = 32'h2;
      is_v = 1; is_a = 5'd7;
      ld_v = 1; ld_a = 5'd7; ld_d = 32'h77;
      step("rst_fill1");
      is_a = 5'd9; ld_a = 5'd9; ld_d = 32'h99;
      step("rst_fill2");
      is_v = 0; ld_v = 0;
      check_val("rst_pend_before", pend, 32'h280);
      #2;
      reset = 1'b1;
      #1;
      check_val("async_we",    {31'd0, rd_we}, 32'd0);
      check_val("async_rd",    rd_data, 32'd0);
      check_val("async_pend",  pend, 32'd0);
      check_val("async_ready", {31'd0, ld_rdy}, 32'd1);
      idle_inputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step($sformatf("post_rst%0d", i));
         check_val("post_rst_no_we", {31'd0, rd_we}, 32'd0);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         alu_v = ($urandom_range(0, 9) < 4);
         alu_a = 5'($urandom_range(0, 31));
         alu_d = $urandom;
         ld_v  = ($urandom_range(0, 1) == 1);
         ld_a  = 5'($urandom_range(0, 31));
         ld_d  = $urandom;
         is_v  = ($urandom_range(0, 2) == 0);
         is_a  = 5'($urandom_range(0, 31));
         step($sformatf("rand%0d", i));
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) step($sformatf("tail%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
